// File: rtl/timer_pkg.sv
// Shared machine-timer constants: register width, peripheral address offsets,
// and the mtimecmp reset value that keeps MTIP low out of reset.
package timer_pkg;
  localparam int unsigned MTIME_W         = 64;
  localparam int unsigned MTIME_OFFSET    = 0;
  localparam int unsigned MTIMECMP_OFFSET = 8;
  localparam logic [MTIME_W-1:0] DEFAULT_RESET_MTIMECMP = {MTIME_W{1'b1}};
endpackage

// File: rtl/mtime_prescaler.sv
// Programmable divider: asserts tick_now once every prescale+1 run cycles.
// A >= compare means lowering prescale below the count ticks on the next run cycle.
module mtime_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  tick_now
);
  logic [PRESCALE_W-1:0] count;

  assign tick_now = run && (count >= i_prescale);

  // An mtime write restarts the divide period so the loaded value gets a full period.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick_now) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mtime_ctrl.sv
// Machine-timer state: mtime counter, mtimecmp register, registered MTIP and tick.
// MTIP is computed from next-state values so it never lags the visible registers.
module mtime_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned          PRESCALE_W     = 16,
  parameter logic [MTIME_W-1:0]   RESET_MTIMECMP = DEFAULT_RESET_MTIMECMP
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_halt,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_mtime_we,
  input  logic                  i_mtimecmp_we,
  input  logic [MTIME_W-1:0]    i_timer_data,
  output logic [MTIME_W-1:0]    o_mtime,
  output logic [MTIME_W-1:0]    o_mtimecmp,
  output logic                  o_mtip,
  output logic                  o_tick
);
  logic               run;
  logic               tick_now;
  logic [MTIME_W-1:0] mtime_next;
  logic [MTIME_W-1:0] mtimecmp_next;

  assign run = i_enable && !i_halt;

  mtime_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .run        (run),
    .clear      (i_mtime_we),
    .i_prescale (i_prescale),
    .tick_now   (tick_now)
  );

  // A software write to mtime wins over a coincident tick.
  always_comb begin
    mtime_next = o_mtime;
    if (i_mtime_we) begin
      mtime_next = i_timer_data;
    end else if (tick_now) begin
      mtime_next = o_mtime + 1'b1;
    end
  end

  always_comb begin
    mtimecmp_next = o_mtimecmp;
    if (i_mtimecmp_we) begin
      mtimecmp_next = i_timer_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mtime    <= '0;
      o_mtimecmp <= RESET_MTIMECMP;
      o_mtip     <= 1'b0;
      o_tick     <= 1'b0;
    end else begin
      o_mtime    <= mtime_next;
      o_mtimecmp <= mtimecmp_next;
      o_mtip     <= (mtime_next >= mtimecmp_next);
      o_tick     <= tick_now && !i_mtime_we;
    end
  end
endmodule

// File: tb/tb_mtime_ctrl.sv
// Directed bench for mtime_ctrl: hand-computed expectations for counting,
// halting, compare/interrupt timing, wrap, reset priority and prescale reduction.
module tb_mtime_ctrl;
  localparam int unsigned PW = 16;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          halt;
  logic [PW-1:0] prescale;
  logic          mtime_we;
  logic          mtimecmp_we;
  logic [63:0]   timer_data;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          mtip;
  logic          tick;

  int checks;
  int errors;

  mtime_ctrl #(.PRESCALE_W(PW)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_halt        (halt),
    .i_prescale    (prescale),
    .i_mtime_we    (mtime_we),
    .i_mtimecmp_we (mtimecmp_we),
    .i_timer_data  (timer_data),
    .o_mtime       (mtime),
    .o_mtimecmp    (mtimecmp),
    .o_mtip        (mtip),
    .o_tick        (tick)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    enable = 1'b0; halt = 1'b0; prescale = '0;
    mtime_we = 1'b0; mtimecmp_we = 1'b0; timer_data = '0;
    reset = 1'b1;
    #2;

    // Reset state
    do_reset();
    check("rst_mtime", mtime, 64'd0);
    check("rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_mtip", {63'd0, mtip}, 64'd0);
    check("rst_tick", {63'd0, tick}, 64'd0);

    // 1: prescale 0 -> increment every cycle
    enable = 1'b1; prescale = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("t1_tick", {63'd0, tick}, 64'd1);
      check("t1_mtime", mtime, 64'(i));
    end
    check("t1_mtip", {63'd0, mtip}, 64'd0);

    // 2: prescale 3 -> tick every 4th run cycle; halts/disable freeze progress
    do_reset();
    prescale = 3;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("t2_tick", {63'd0, tick}, (i % 4 == 0) ? 64'd1 : 64'd0);
    end
    check("t2_mtime12", mtime, 64'd3);
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_halt_mtime", mtime, 64'd3);
      check("t2_halt_tick", {63'd0, tick}, 64'd0);
    end
    halt = 1'b0;
    step(); step(); step();
    check("t2_rel_pre", mtime, 64'd3);
    step();
    check("t2_rel_mtime", mtime, 64'd4);
    check("t2_rel_tick", {63'd0, tick}, 64'd1);
    step(); step();
    enable = 1'b0;
    step(); step(); step();
    check("t2_dis_mtime", mtime, 64'd4);
    enable = 1'b1;
    step();
    check("t2_en_pre", mtime, 64'd4);
    step();
    check("t2_en_mtime", mtime, 64'd5);

    // 3: compare match and mtimecmp raise
    do_reset();
    prescale = 0;
    mtimecmp_we = 1'b1; timer_data = 64'd20;
    step();
    mtimecmp_we = 1'b0;
    check("t3_cmp", mtimecmp, 64'd20);
    check("t3_mtime1", mtime, 64'd1);
    for (int k = 2; k <= 20; k++) begin
      step();
      check("t3_mtip", {63'd0, mtip}, (k >= 20) ? 64'd1 : 64'd0);
    end
    check("t3_mtime20", mtime, 64'd20);
    mtimecmp_we = 1'b1; timer_data = 64'd100;
    step();
    mtimecmp_we = 1'b0;
    check("t3_cmp100", mtimecmp, 64'd100);
    check("t3_mtip_low", {63'd0, mtip}, 64'd0);
    check("t3_mtime21", mtime, 64'd21);

    // 4: mtime write overrides a tick, then wraps
    mtimecmp_we = 1'b1; timer_data = 64'd5;
    step();
    mtimecmp_we = 1'b0;
    mtime_we = 1'b1; timer_data = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    mtime_we = 1'b0;
    check("t4_mtime_fe", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t4_tick0", {63'd0, tick}, 64'd0);
    check("t4_mtip1", {63'd0, mtip}, 64'd1);
    step();
    check("t4_mtime_ff", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("t4_wrap", mtime, 64'd0);
    check("t4_wrap_tick", {63'd0, tick}, 64'd1);
    check("t4_mtip0", {63'd0, mtip}, 64'd0);

    // 5: reset beats simultaneous writes
    step(); step();
    reset = 1'b1; mtime_we = 1'b1; mtimecmp_we = 1'b1; timer_data = 64'd123;
    step();
    reset = 1'b0; mtime_we = 1'b0; mtimecmp_we = 1'b0;
    check("t5_mtime", mtime, 64'd0);
    check("t5_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_mtip", {63'd0, mtip}, 64'd0);
    check("t5_tick", {63'd0, tick}, 64'd0);

    // 6: lowering prescale below the count ticks on the next run cycle
    prescale = 10;
    for (int i = 0; i < 7; i++) step();
    check("t6_pre", mtime, 64'd0);
    prescale = 2;
    step();
    check("t6_tick", {63'd0, tick}, 64'd1);
    check("t6_mtime1", mtime, 64'd1);
    step(); step();
    check("t6_hold", mtime, 64'd1);
    step();
    check("t6_mtime2", mtime, 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
